// File: rtl/circle_readout_seq_pkg.sv
// Shared types and constants for the circular-buffer readout sequencer.
package circle_readout_seq_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSelect,
      StRead,
      StFlush
   } state_e;

   localparam int unsigned FifoDepth = 2;

   // Index width for n items, never narrower than one bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r = r + 1;
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-one finder: scans req starting at start, wrapping at N.
module rr_pick
   import circle_readout_seq_pkg::*;
#(
   parameter int unsigned N = 4,
   parameter int unsigned W = clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic [W-1:0] idx,
   output logic         found
);

   logic [W-1:0] cand;

   always_comb begin
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int unsigned i = 0; i < N; i++) begin
         cand = W'((32'(start) + i) % N);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/circle_readout_seq.sv
// Round-robin bank drain from per-channel circular buffers into a tagged valid/ready stream.
module circle_readout_seq
   import circle_readout_seq_pkg::*;
#(
   parameter int unsigned CHANS     = 7,
   parameter int unsigned DWIDTH    = 16,
   parameter int unsigned BUF_AW    = 13,
   parameter int unsigned WID_CHANS = clog2(CHANS)
) (
   input  logic                    rclk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic [CHANS-1:0]        chan_mask,
   input  logic                    abort,
   input  logic [CHANS-1:0]        wave_available,
   input  logic [DWIDTH*CHANS-1:0] wave_result,
   output logic [CHANS-1:0]        stb_r,
   output logic [CHANS-1:0]        rewind,
   output logic [DWIDTH-1:0]       out_data,
   output logic [WID_CHANS-1:0]    out_chan,
   output logic                    out_first,
   output logic                    out_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    busy
);

   localparam int unsigned PtrW = clog2(FifoDepth);
   localparam int unsigned CntW = clog2(FifoDepth + 1);
   localparam int unsigned OccW = CntW + 1;

   state_e               state_q;
   logic [WID_CHANS-1:0] cur_ch_q;
   logic [WID_CHANS-1:0] rr_ptr_q;
   logic [WID_CHANS-1:0] next_ch;
   logic [WID_CHANS-1:0] pick_idx;
   logic                 pick_found;
   logic [BUF_AW-1:0]    word_cnt_q;
   logic [BUF_AW-1:0]    word_idx_q;
   logic                 inflight_q;
   logic [CHANS-1:0]     rewind_q;

   logic [DWIDTH-1:0]    fifo_data_q  [FifoDepth];
   logic [WID_CHANS-1:0] fifo_chan_q  [FifoDepth];
   logic [FifoDepth-1:0] fifo_first_q;
   logic [FifoDepth-1:0] fifo_last_q;
   logic [PtrW-1:0]      rd_ptr_q;
   logic [PtrW-1:0]      wr_ptr_q;
   logic [CntW-1:0]      fifo_cnt_q;

   logic                 abort_act;
   logic                 push;
   logic                 pop;
   logic                 strobe;
   logic [OccW-1:0]      occ;
   logic [DWIDTH-1:0]    cur_word;

   rr_pick #(
      .N (CHANS),
      .W (WID_CHANS)
   ) u_rr_pick (
      .req   (wave_available & chan_mask),
      .start (rr_ptr_q),
      .idx   (pick_idx),
      .found (pick_found)
   );

   assign abort_act = abort && (state_q == StRead || state_q == StFlush);
   assign out_valid = (fifo_cnt_q != '0);
   assign pop       = out_valid && out_ready;
   // An aborted bank's in-flight word is dropped instead of entering the FIFO.
   assign push      = inflight_q && !abort_act;
   assign occ       = OccW'(fifo_cnt_q) + OccW'(inflight_q) - OccW'(pop);
   assign strobe    = (state_q == StRead) && !abort_act && (occ < OccW'(FifoDepth));
   assign next_ch   = (cur_ch_q == WID_CHANS'(CHANS - 1)) ? '0 : cur_ch_q + 1'b1;
   assign cur_word  = wave_result[cur_ch_q*DWIDTH +: DWIDTH];

   always_comb begin
      stb_r = '0;
      if (strobe) stb_r[cur_ch_q] = 1'b1;
   end

   always_ff @(posedge rclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cur_ch_q   <= '0;
         rr_ptr_q   <= '0;
         word_cnt_q <= '0;
         word_idx_q <= '0;
         inflight_q <= 1'b0;
         rewind_q   <= '0;
      end else begin
         inflight_q <= strobe;
         rewind_q   <= '0;
         if (strobe) begin
            word_idx_q <= word_cnt_q;
            word_cnt_q <= word_cnt_q + 1'b1;
         end
         if (abort_act) begin
            rewind_q[cur_ch_q] <= 1'b1;
            rr_ptr_q           <= next_ch;
            state_q            <= StIdle;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (enable && (wave_available & chan_mask) != '0) state_q <= StSelect;
               end
               StSelect: begin
                  word_cnt_q <= '0;
                  if (pick_found) begin
                     cur_ch_q <= pick_idx;
                     state_q  <= StRead;
                  end else begin
                     state_q <= StIdle;
                  end
               end
               StRead: begin
                  if (strobe && word_cnt_q == '1) state_q <= StFlush;
               end
               StFlush: begin
                  if (!inflight_q && fifo_cnt_q == '0) begin
                     rr_ptr_q <= next_ch;
                     state_q  <= StIdle;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   always_ff @(posedge rclk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         fifo_cnt_q   <= '0;
         fifo_first_q <= '0;
         fifo_last_q  <= '0;
         for (int i = 0; i < FifoDepth; i++) begin
            fifo_data_q[i] <= '0;
            fifo_chan_q[i] <= '0;
         end
      end else if (abort_act) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         if (push) begin
            fifo_data_q[wr_ptr_q]  <= cur_word;
            fifo_chan_q[wr_ptr_q]  <= cur_ch_q;
            fifo_first_q[wr_ptr_q] <= (word_idx_q == '0);
            fifo_last_q[wr_ptr_q]  <= (word_idx_q == '1);
            wr_ptr_q               <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         fifo_cnt_q <= fifo_cnt_q + CntW'(push) - CntW'(pop);
      end
   end

   assign out_data  = fifo_data_q[rd_ptr_q];
   assign out_chan  = fifo_chan_q[rd_ptr_q];
   assign out_first = fifo_first_q[rd_ptr_q];
   assign out_last  = fifo_last_q[rd_ptr_q];
   assign rewind    = rewind_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_circle_readout_seq.sv
// Bench for circle_readout_seq: buffer model, randomized handshake and a bank-level stream model.
module tb_circle_readout_seq;

   logic        rclk;
   logic        rst_n;
   logic        enable;
   logic [2:0]  chan_mask;
   logic        abort;
   logic [2:0]  wave_available;
   logic [47:0] wave_result;
   logic [2:0]  stb_r;
   logic [2:0]  rewind;
   logic [15:0] out_data;
   logic [1:0]  out_chan;
   logic        out_first;
   logic        out_last;
   logic        out_valid;
   logic        out_ready;
   logic        busy;

   circle_readout_seq #(
      .CHANS  (3),
      .DWIDTH (16),
      .BUF_AW (3)
   ) dut (
      .rclk           (rclk),
      .rst_n          (rst_n),
      .enable         (enable),
      .chan_mask      (chan_mask),
      .abort          (abort),
      .wave_available (wave_available),
      .wave_result    (wave_result),
      .stb_r          (stb_r),
      .rewind         (rewind),
      .out_data       (out_data),
      .out_chan       (out_chan),
      .out_first      (out_first),
      .out_last       (out_last),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .busy           (busy)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   int n_checks = 0;
   int n_errors = 0;
   int ready_mode = 0;

   // Buffer model: bank requests per channel, each word reads back as {ch, word_idx}.
   int          req    [3] = '{0, 0, 0};
   int          served [3] = '{0, 0, 0};
   int          widx   [3];
   logic [15:0] bdata  [3];

   always_comb begin
      for (int c = 0; c < 3; c++) wave_available[c] = (req[c] > served[c]);
   end
   assign wave_result = {bdata[2], bdata[1], bdata[0]};

   always @(posedge rclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < 3; c++) begin
            widx[c]  <= 0;
            bdata[c] <= '0;
         end
      end else begin
         for (int c = 0; c < 3; c++) begin
            if (rewind[c]) begin
               widx[c] <= 0;
            end else if (stb_r[c]) begin
               bdata[c] <= {8'(c), 8'(widx[c])};
               widx[c]  <= (widx[c] + 1) % 8;
               if (widx[c] == 7) served[c] <= served[c] + 1;
            end
         end
      end
   end

   // Stream monitor: records accepted words and protocol violations.
   logic [19:0] got_q [$];
   logic [19:0] exp_q [$];
   int          base = 0;
   int          stall_bad = 0;
   int          hot_bad = 0;
   int          rew_bad = 0;
   int          occ = 0;
   int          occ_max = 0;
   logic        occ_en = 1'b0;
   logic        abort_win = 1'b0;
   logic        pv = 1'b0;
   logic [20:0] prev_bus = '0;
   logic [20:0] cur_bus;

   assign cur_bus = {out_valid, out_chan, out_first, out_last, out_data};

   always @(negedge rclk) begin
      if (rst_n) begin
         if (out_valid && out_ready) got_q.push_back({out_chan, out_first, out_last, out_data});
         if (pv && !abort_win && cur_bus !== prev_bus) stall_bad <= stall_bad + 1;
         if (stb_r != 3'b000 && (!$onehot(stb_r) || !busy)) hot_bad <= hot_bad + 1;
         if (rewind != 3'b000 && !abort_win) rew_bad <= rew_bad + 1;
         if (occ_en) occ <= occ + int'(stb_r != 3'b000) - int'(out_valid && out_ready);
         else        occ <= 0;
         if (occ > occ_max) occ_max <= occ;
      end
      pv       <= rst_n && out_valid && !out_ready;
      prev_bus <= cur_bus;
   end

   // Bank-level reference: round-robin over channels with pending banks and mask set.
   int mdone [3] = '{0, 0, 0};
   int mptr = 0;

   task automatic model_banks(input int nb);
      int pick;
      int c;
      for (int b = 0; b < nb; b++) begin
         pick = -1;
         for (int k = 0; k < 3; k++) begin
            c = (mptr + k) % 3;
            if (pick < 0 && chan_mask[c] && req[c] > mdone[c]) pick = c;
         end
         if (pick < 0) break;
         for (int w = 0; w < 8; w++) exp_q.push_back({2'(pick), w == 0, w == 7, 8'(pick), 8'(w)});
         mdone[pick] = mdone[pick] + 1;
         mptr = (pick + 1) % 3;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic cyc();
      @(posedge rclk);
      #1;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ~out_ready;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_stb"}, 32'(stb_r), 0);
      check({tag, "_rewind"}, 32'(rewind), 0);
      check({tag, "_valid"}, 32'(out_valid), 0);
      check({tag, "_data"}, 32'(out_data), 0);
      check({tag, "_chan"}, 32'(out_chan), 0);
      check({tag, "_first"}, 32'(out_first), 0);
      check({tag, "_last"}, 32'(out_last), 0);
      check({tag, "_busy"}, 32'(busy), 0);
   endtask

   task automatic wait_strobe(input string tag, input logic [2:0] expv);
      for (int i = 0; i < 200 && stb_r == 3'b000; i++) cyc();
      check(tag, 32'(stb_r), 32'(expv));
   endtask

   task automatic wait_idle(input string tag);
      int quiet;
      quiet = 0;
      for (int i = 0; i < 3000 && quiet < 6; i++) begin
         cyc();
         quiet = busy ? 0 : quiet + 1;
      end
      check({tag, "_idle"}, 32'(quiet >= 6), 1);
   endtask

   task automatic compare(input string tag);
      check({tag, "_len"}, 32'(got_q.size() - base), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++)
         check(tag, 32'(got_q[base + i]), 32'(exp_q[i]));
      base = got_q.size();
      exp_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before the bench finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int n;
      int nb;
      rst_n     = 1'b0;
      enable    = 1'b0;
      abort     = 1'b0;
      out_ready = 1'b0;
      chan_mask = 3'b111;
      #3;
      check_zero("reset");
      repeat (2) cyc();
      rst_n  = 1'b1;
      enable = 1'b1;

      // Single bank from ch1 with the sink always ready.
      req[1]++;
      model_banks(10);
      wait_strobe("single_first_stb", 3'b010);
      for (int i = 0; i < 8; i++) begin
         check("single_stb_run", 32'(stb_r), 32'(3'b010));
         cyc();
      end
      check("single_stb_end", 32'(stb_r), 0);
      wait_idle("single");
      compare("single_word");

      // Round-robin from a fresh pointer with a random sink.
      rst_n = 1'b0;
      #1;
      check_zero("rr_reset");
      cyc();
      rst_n = 1'b1;
      mptr = 0;
      ready_mode = 2;
      req[0] += 2;
      req[1]++;
      req[2]++;
      model_banks(10);
      wait_idle("rr");
      compare("rr_word");

      // Alternating backpressure.
      ready_mode = 1;
      occ_en = 1'b1;
      req[1]++;
      req[2]++;
      model_banks(10);
      wait_idle("bp");
      compare("bp_word");
      check("bp_occupancy_le2", 32'(occ_max <= 2), 1);
      occ_en = 1'b0;

      // Abort partway through a ch2 bank.
      ready_mode = 2;
      k = int'($urandom_range(2, 6));
      req[2]++;
      n = 0;
      for (int i = 0; i < 400 && n < k; i++) begin
         cyc();
         if (stb_r != 3'b000) begin
            n++;
            if (n == 1) req[0]++;
         end
      end
      check("abort_pre_stb", 32'(stb_r), 32'(3'b100));
      cyc();
      abort = 1'b1;
      abort_win = 1'b1;
      #1;
      check("abort_no_stb", 32'(stb_r), 0);
      cyc();
      abort = 1'b0;
      check("abort_rewind", 32'(rewind), 32'(3'b100));
      check("abort_valid_low", 32'(out_valid), 0);
      check("abort_idle", 32'(busy), 0);
      cyc();
      check("abort_rewind_once", 32'(rewind), 0);
      abort_win = 1'b0;
      base = got_q.size();
      mptr = 0;
      model_banks(10);
      wait_strobe("abort_next_ch0", 3'b001);
      wait_idle("abort");
      compare("abort_word");

      // Masked channel is never served.
      chan_mask = 3'b101;
      req[0]++;
      req[1]++;
      req[2]++;
      model_banks(10);
      wait_idle("mask");
      compare("mask_word");
      check("mask_ch1_pending", 32'(wave_available[1]), 1);
      check("mask_ch1_ignored", 32'(busy), 0);

      // Enable dropped mid-bank: bank completes, nothing new starts.
      enable = 1'b0;
      chan_mask = 3'b111;
      req[0]++;
      cyc();
      enable = 1'b1;
      wait_strobe("en_first_stb", 3'b001);
      repeat (2) cyc();
      enable = 1'b0;
      model_banks(1);
      wait_idle("en");
      compare("en_word");
      nb = 0;
      repeat (20) begin
         cyc();
         if (busy || stb_r != 3'b000) nb++;
      end
      check("en_no_new_select", 32'(nb), 0);

      // Asynchronous reset in the middle of a ch1 bank.
      enable = 1'b1;
      wait_strobe("arst_pre_stb", 3'b010);
      repeat (3) cyc();
      #1;
      rst_n = 1'b0;
      #1;
      check_zero("arst");
      mptr = 0;
      req[0]++;
      repeat (2) cyc();
      rst_n = 1'b1;
      base = got_q.size();
      model_banks(10);
      wait_strobe("arst_next_ch0", 3'b001);
      wait_idle("arst");
      compare("arst_word");

      check("stall_stable", 32'(stall_bad), 0);
      check("stb_onehot_busy", 32'(hot_bad), 0);
      check("rewind_only_abort", 32'(rew_bad), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
